decimal_to_c2_encoder: RTL and testbench

//  Sequential encoder: accepts a signed decimal number one BCD digit at a time, plus sign and enter keys.

---
 rtl/decoder_pkg.sv | 31 +++
 rtl/decimal_to_c2_encoder_bcd_mac_step.sv | 29 ++
 rtl/decimal_to_c2_encoder.sv | 152 +++++++++++++++
 tb/tb_decimal_to_c2_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types, constants and limit helpers for the
//                decimal to two's complement encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package decoder_pkg;

  // Entry state machine encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    RESULT = 2'd2
  } enc_state_e;

  // Largest legal BCD digit value
  localparam int BCD_MAX = 9;

  // Largest magnitude representable as a positive DW-bit two's complement value
  function automatic int unsigned pos_limit(input int unsigned dw);
    return (32'd1 << (dw - 1)) - 32'd1;
  endfunction

  // Largest magnitude representable as a negative DW-bit two's complement value
  function automatic int unsigned neg_limit(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decimal_to_c2_encoder_bcd_mac_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mac_step
//  Description : Combinational decimal shift-in step: acc*10 + digit, plus a
//                flag telling whether the digit is a legal BCD value.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mac_step
  import decoder_pkg::*;
#(
  parameter int AW           = 12,
  parameter int NUMBER_WIDTH = 4
) (
  input  logic [AW-1:0]           acc,
  input  logic [NUMBER_WIDTH-1:0] digit,
  output logic [AW-1:0]           next_acc,
  output logic                    digit_ok
);

  localparam logic [NUMBER_WIDTH-1:0] DIGIT_MAX = NUMBER_WIDTH'(BCD_MAX);

  // Multiply by ten as shift-and-add, then append the new digit
  always_comb begin
    next_acc = (acc << 3) + (acc << 1) + {{(AW-NUMBER_WIDTH){1'b0}}, digit};
    digit_ok = (digit <= DIGIT_MAX);
  end

endmodule
`default_nettype wire

// File: rtl/decimal_to_c2_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : decimal_to_c2_encoder
//  Description : Collects a signed decimal number digit by digit (MSD first)
//                with sign toggle, enter and clear keys, and emits the
//                saturated DW-bit two's complement value with a valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module decimal_to_c2_encoder
  import decoder_pkg::*;
#(
  parameter int DW           = 8,
  parameter int MAX_DIGITS   = 3,
  parameter int NUMBER_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUMBER_WIDTH-1:0]           digit,
  input  logic                              digit_valid,
  output logic                              digit_ready,
  input  logic                              sign_key,
  input  logic                              enter,
  input  logic                              clear,
  output logic [DW-1:0]                     number,
  output logic                              number_valid,
  output logic                              overflow,
  output logic                              digit_err,
  output logic                              neg_pending,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count
);

  localparam int AW = DW + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [AW-1:0] POS_LIM   = AW'(pos_limit(DW));
  localparam logic [AW-1:0] NEG_LIM   = AW'(neg_limit(DW));
  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_DIGITS);
  localparam logic [DW-1:0] MAX_VAL   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_VAL   = {1'b1, {(DW-1){1'b0}}};

  enc_state_e      state;
  enc_state_e      state_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mac_next;
  logic            digit_ok;
  logic [DW-1:0]   res_number;
  logic            res_ovf;
  logic [DW-1:0]   sat_number;
  logic            sat_ovf;
  logic            in_entry;
  logic            do_clear;
  logic            do_enter;
  logic            do_digit;
  logic            do_sign;
  logic            digit_accept;

  bcd_mac_step #(
    .AW           (AW),
    .NUMBER_WIDTH (NUMBER_WIDTH)
  ) u_mac (
    .acc      (acc),
    .digit    (digit),
    .next_acc (mac_next),
    .digit_ok (digit_ok)
  );

  // Key decode with priority clear > enter > digit > sign; nothing is taken in RESULT
  always_comb begin
    in_entry     = (state != RESULT);
    do_clear     = in_entry && clear;
    do_enter     = in_entry && !clear && enter;
    do_digit     = in_entry && !clear && !enter && digit_valid;
    do_sign      = in_entry && !clear && !enter && !digit_valid && sign_key;
    digit_accept = do_digit && digit_ok && (digit_count < MAX_COUNT);
  end

  // Range check and saturation of the pending magnitude with its sign
  always_comb begin
    sat_ovf = neg_pending ? (acc > NEG_LIM) : (acc > POS_LIM);
    if (sat_ovf) begin
      sat_number = neg_pending ? MIN_VAL : MAX_VAL;
    end else begin
      sat_number = neg_pending ? (~acc[DW-1:0] + DW'(1)) : acc[DW-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RESULT lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    if (state == RESULT) begin
      state_nxt = IDLE;
    end else if (do_clear) begin
      state_nxt = IDLE;
    end else if (do_enter) begin
      state_nxt = RESULT;
    end else if (digit_accept || do_sign) begin
      state_nxt = ENTRY;
    end
  end

  // Entry datapath: accumulator, digit count, sign, and staged result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      digit_count  <= '0;
      neg_pending  <= 1'b0;
      res_number   <= '0;
      res_ovf      <= 1'b0;
      number       <= '0;
      overflow     <= 1'b0;
      number_valid <= 1'b0;
      digit_err    <= 1'b0;
    end else begin
      number_valid <= (state == RESULT);
      digit_err    <= do_digit && !digit_accept;
      // The result staged on enter becomes visible as RESULT ends
      if (state == RESULT) begin
        number   <= res_number;
        overflow <= res_ovf;
      end
      if (do_clear) begin
        acc         <= '0;
        digit_count <= '0;
        neg_pending <= 1'b0;
      end else if (do_enter) begin
        res_number  <= sat_number;
        res_ovf     <= sat_ovf;
        acc         <= '0;
        digit_count <= '0;
        neg_pending <= 1'b0;
      end else if (digit_accept) begin
        acc         <= mac_next;
        digit_count <= digit_count + CW'(1);
      end else if (do_sign) begin
        neg_pending <= ~neg_pending;
      end
    end
  end

  assign digit_ready = (state != RESULT);

endmodule
`default_nettype wire

// File: tb/tb_decimal_to_c2_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decimal_to_c2_encoder
//  Description : Directed, table-driven bench for decimal_to_c2_encoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decimal_to_c2_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = '0;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic       sign_key = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] number;
  logic       number_valid;
  logic       overflow;
  logic       digit_err;
  logic       neg_pending;
  logic [1:0] digit_count;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic            neg;
    int              nd;
    logic [2:0][3:0] ds;    // ds[0] is the first digit keyed
    logic [7:0]      num;
    logic            ovf;
  } vec_t;

  vec_t vt [10];

  decimal_to_c2_encoder #(.DW(8), .MAX_DIGITS(3), .NUMBER_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .sign_key     (sign_key),
    .enter        (enter),
    .clear        (clear),
    .number       (number),
    .number_valid (number_valid),
    .overflow     (overflow),
    .digit_err    (digit_err),
    .neg_pending  (neg_pending),
    .digit_count  (digit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic key_digit(input logic [3:0] d);
    @(negedge clk);
    digit = d;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic key_sign();
    @(negedge clk);
    sign_key = 1'b1;
    @(negedge clk);
    sign_key = 1'b0;
  endtask

  // Press enter and check the one-cycle-later result and the valid pulse width
  task automatic run_enter(input string tag, input logic [7:0] en, input logic eo);
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    check({tag, "_ready_low"}, 32'(digit_ready), 32'd0);
    check({tag, "_early_valid"}, 32'(number_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(number_valid), 32'd1);
    check({tag, "_number"}, 32'(number), 32'(en));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_neg_after"}, 32'(neg_pending), 32'd0);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(number_valid), 32'd0);
    check({tag, "_number_hold"}, 32'(number), 32'(en));
  endtask

  initial begin
    vt[0] = '{1'b0, 3, {4'd7, 4'd2, 4'd1}, 8'h7F, 1'b0};
    vt[1] = '{1'b1, 3, {4'd8, 4'd2, 4'd1}, 8'h80, 1'b0};
    vt[2] = '{1'b0, 3, {4'd0, 4'd0, 4'd2}, 8'h7F, 1'b1};
    vt[3] = '{1'b1, 3, {4'd9, 4'd2, 4'd1}, 8'h80, 1'b1};
    vt[4] = '{1'b0, 3, {4'd7, 4'd0, 4'd0}, 8'h07, 1'b0};
    vt[5] = '{1'b1, 2, {4'd0, 4'd2, 4'd4}, 8'hD6, 1'b0};
    vt[6] = '{1'b1, 1, {4'd0, 4'd0, 4'd0}, 8'h00, 1'b0};
    vt[7] = '{1'b1, 3, {4'd7, 4'd2, 4'd1}, 8'h81, 1'b0};
    vt[8] = '{1'b0, 3, {4'd8, 4'd2, 4'd1}, 8'h7F, 1'b1};
    vt[9] = '{1'b1, 3, {4'd9, 4'd9, 4'd9}, 8'h80, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_number", 32'(number), 32'd0);
    check("rst_valid", 32'(number_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(digit_err), 32'd0);
    check("rst_neg", 32'(neg_pending), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_ready", 32'(digit_ready), 32'd1);

    // Illegal BCD digit in IDLE
    key_digit(4'hA);
    check("bad_digit_err", 32'(digit_err), 32'd1);
    check("bad_digit_count", 32'(digit_count), 32'd0);
    @(negedge clk);
    check("bad_digit_err_pulse", 32'(digit_err), 32'd0);

    // Fourth digit rejected, accumulator keeps 123
    key_digit(4'd1);
    key_digit(4'd2);
    key_digit(4'd3);
    check("three_digits_err", 32'(digit_err), 32'd0);
    key_digit(4'd4);
    check("fourth_digit_err", 32'(digit_err), 32'd1);
    check("fourth_digit_count", 32'(digit_count), 32'd3);
    run_enter("acc123", 8'h7B, 1'b0);

    // clear wins over enter in the same cycle
    key_digit(4'd5);
    check("clr_pre_count", 32'(digit_count), 32'd1);
    @(negedge clk);
    clear = 1'b1;
    enter = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enter = 1'b0;
    check("clr_count", 32'(digit_count), 32'd0);
    check("clr_ready", 32'(digit_ready), 32'd1);
    check("clr_valid0", 32'(number_valid), 32'd0);
    @(negedge clk);
    check("clr_valid1", 32'(number_valid), 32'd0);
    check("clr_number_kept", 32'(number), 32'h7B);
    @(negedge clk);
    check("clr_valid2", 32'(number_valid), 32'd0);

    // Enter with no digits
    run_enter("idle_enter", 8'h00, 1'b0);

    // Digit strobe during RESULT is ignored
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    digit = 4'd9;
    digit_valid = 1'b1;
    check("res_ready_low", 32'(digit_ready), 32'd0);
    @(negedge clk);
    digit_valid = 1'b0;
    check("res_valid", 32'(number_valid), 32'd1);
    check("res_number", 32'(number), 32'd0);
    check("res_digit_err", 32'(digit_err), 32'd0);
    check("res_digit_count", 32'(digit_count), 32'd0);

    // Table of complete entries
    for (int i = 0; i < 10; i++) begin
      if (vt[i].neg) begin
        key_sign();
        check($sformatf("v%0d_neg_pending", i), 32'(neg_pending), 32'd1);
      end
      for (int k = 0; k < vt[i].nd; k++) key_digit(vt[i].ds[k]);
      check($sformatf("v%0d_count", i), 32'(digit_count), 32'(vt[i].nd));
      check($sformatf("v%0d_neg_before", i), 32'(neg_pending), 32'(vt[i].neg));
      run_enter($sformatf("v%0d", i), vt[i].num, vt[i].ovf);
    end

    // Reset in the middle of an entry
    key_sign();
    key_digit(4'd4);
    key_digit(4'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_number", 32'(number), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_neg", 32'(neg_pending), 32'd0);
    check("mid_rst_count", 32'(digit_count), 32'd0);
    check("mid_rst_valid", 32'(number_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_valid_after", 32'(number_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
